iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL be legal for any WIDTH >= 2.
REQ-002 Parameter STEP, default 1, maximum bit positions shifted per SHIFT cycle; legal range 1..WIDTH-1.
REQ-003 Derived SAW = $clog2(WIDTH), the shift-amount width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  block accepts a request this cycle.
REQ-009 in_data  in  WIDTH  operand.
REQ-010 in_shamt  in  SAW  shift amount, 0..WIDTH-1.
REQ-011 in_mode  in  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 illegal.
REQ-012 abort  in  1  synchronous cancel of the in-flight operation.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_data  out  WIDTH  shifted result.
REQ-016 out_carry  out  1  last bit shifted or rotated out; 0 when no shift occurred.
REQ-017 out_zero  out  1  out_data == 0.
REQ-018 out_err  out  1  request carried an illegal mode.

Function
REQ-019 FSM states: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-020 Accept occurs at a rising edge with in_valid & in_ready; data, shamt and mode are latched; remaining count = shamt.
REQ-021 IDLE -> SHIFT on accept when shamt != 0 and mode is LSL/LSR/ASR/ROL/ROR; otherwise IDLE -> DONE.
REQ-022 Each SHIFT cycle shifts by n = min(STEP, remaining) and decrements remaining by n; SHIFT -> DONE when remaining reaches 0.
REQ-023 Latency: accept at edge T -> out_valid high from cycle T+1+ceil(shamt/STEP); pass, illegal or shamt 0 -> out_valid from T+1.
REQ-024 LSL fills 0 at the LSB; LSR fills 0 at the MSB; ASR replicates the original MSB; ROL/ROR recirculate bits; no bit is lost in rotates.
REQ-025 out_carry = the last bit to leave the word boundary (LSL: old bit WIDTH-shamt; LSR/ASR: old bit shamt-1; ROL: new bit 0; ROR: new bit WIDTH-1).
REQ-026 Illegal mode: out_data = in_data, out_carry = 0, out_err = 1; shamt is ignored.
REQ-027 out_data, out_carry, out_zero and out_err SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-028 DONE -> IDLE on out_valid & out_ready; the next accept is earliest one cycle later (no same-cycle turnaround).
REQ-029 abort in SHIFT or DONE -> IDLE at the next edge with no result delivered; abort in IDLE is ignored; abort wins over a simultaneous out handshake.
REQ-030 in_shamt values >= WIDTH (non-power-of-two WIDTH) SHALL saturate to WIDTH-1.
REQ-031 Input signals are ignored outside the accept cycle.

Reset
REQ-032 rst_n low SHALL force IDLE immediately, independent of clk, including during SHIFT or DONE; the in-flight operation is discarded.
REQ-033 In reset: in_ready = 0, out_valid = 0, out_data = 0, out_carry = 0, out_zero = 0, out_err = 0; in_ready = 1 from the first edge after rst_n rises.

Verification (WIDTH=16, STEP=1 unless stated)
REQ-034 ASR 0x8001 by 3, out_ready = 1 -> out_valid 4 cycles after accept, out_data 0xF000, carry 0, zero 0.
REQ-035 ROL 0x8001 by 1 -> 0x0003, carry 1; ROR 0x0001 by 15 -> 0x0002, carry 0; LSR 0x0001 by 1 -> 0x0000, carry 1, zero 1.
REQ-036 STEP=4, LSL 0x00FF by 6 -> SHIFT lasts 2 cycles, out_data 0x3FC0, carry 0; shamt 0 -> out_valid at T+1, carry 0.
REQ-037 out_ready held low 5 cycles in DONE -> outputs constant; in_ready = 0 throughout; in_ready returns 1 one cycle after the handshake.
REQ-038 mode 111 with in_data 0x1234 -> out_data 0x1234, out_err 1, out_valid at T+1.
REQ-039 rst_n low mid-SHIFT, and separately abort mid-SHIFT -> no out_valid pulse, IDLE, and a following LSL 0x0001 by 2 returns 0x0004.

Source files
------------

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request and result handshake bundle for iter_shifter
interface iter_shifter_if #(parameter int WIDTH = 16);
  localparam int SAW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SAW-1:0]   in_shamt;
  logic [2:0]       in_mode;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;
  modport master (
    output in_valid, in_data, in_shamt, in_mode, abort, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, abort, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter/rotator moving at most STEP bit positions per SHIFT cycle
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input logic          clk,
  input logic          rst_n,
  iter_shifter_if.slave bus
);
  localparam int SAW = $clog2(WIDTH);
  localparam logic [SAW:0]   W_L    = (SAW+1)'(WIDTH);
  localparam logic [SAW-1:0] STEP_L = SAW'(STEP);
  localparam logic [SAW-1:0] MAX_L  = SAW'(WIDTH-1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic             rdy_q, vld_q, carry_q, zero_q, err_q;
  logic [WIDTH-1:0] data_q, sh_d, lsl, lsr, asr, hi;
  logic [SAW-1:0]   rem_q, n, sat;
  logic [SAW:0]     nw;
  logic [2:0]       mode_q;
  logic             c_d, acc, ill, go;
  always_comb begin
    n    = (rem_q < STEP_L) ? rem_q : STEP_L;
    nw   = W_L - {1'b0, n};
    lsl  = data_q << n;
    lsr  = data_q >> n;
    asr  = $unsigned($signed(data_q) >>> n);
    hi   = data_q >> nw;
    sh_d = mode_q == 3'd1 ? lsl :
           mode_q == 3'd2 ? lsr :
           mode_q == 3'd3 ? asr :
           mode_q == 3'd4 ? (lsl | hi) : (lsr | (data_q << nw));
    // hi[0] holds the bit that crosses the MSB boundary on a left shift by n
    c_d  = mode_q == 3'd1 ? hi[0] :
           mode_q == 3'd4 ? sh_d[0] :
           mode_q == 3'd5 ? sh_d[WIDTH-1] : data_q[n - SAW'(1)];
    sat  = ({1'b0, bus.in_shamt} >= W_L) ? MAX_L : bus.in_shamt;
    ill  = bus.in_mode[2] & bus.in_mode[1];
    acc  = bus.in_valid & rdy_q;
    go   = (sat != '0) & (bus.in_mode != 3'd0) & !ill;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 3'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= !acc;
          if (acc) begin
            data_q  <= bus.in_data;
            rem_q   <= sat;
            mode_q  <= bus.in_mode;
            carry_q <= 1'b0;
            err_q   <= ill;
            zero_q  <= bus.in_data == '0;
            vld_q   <= !go;
            state_q <= go ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            data_q  <= sh_d;
            carry_q <= c_d;
            zero_q  <= sh_d == '0;
            rem_q   <= rem_q - n;
            if (rem_q == n) begin
              state_q <= DONE;
              vld_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.abort | bus.out_ready) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: drives STEP=1 and STEP=4 shifters in lockstep and checks both against an arithmetic model
module tb_iter_shifter;
  localparam int W = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  logic [2:0]  in_mode = '0;
  int          vecs = 0, errs = 0;
  always #5 clk = ~clk;
  iter_shifter_if #(.WIDTH(W)) b1 ();
  iter_shifter_if #(.WIDTH(W)) b4 ();
  assign b1.in_valid = in_valid;  assign b4.in_valid = in_valid;
  assign b1.in_data  = in_data;   assign b4.in_data  = in_data;
  assign b1.in_shamt = in_shamt;  assign b4.in_shamt = in_shamt;
  assign b1.in_mode  = in_mode;   assign b4.in_mode  = in_mode;
  assign b1.abort    = abort;     assign b4.abort    = abort;
  assign b1.out_ready = out_ready; assign b4.out_ready = out_ready;
  iter_shifter #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  iter_shifter #(.WIDTH(W), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    logic [2:0]  m;
    logic [15:0] d;
    logic [3:0]  s;
    logic [15:0] r;
    logic        c, z, e;
  } vec_t;

  // {in_ready, out_valid, out_data, out_carry, out_zero, out_err}
  function automatic logic [20:0] snap(input int k);
    return k != 0 ? {b4.in_ready, b4.out_valid, b4.out_data, b4.out_carry, b4.out_zero, b4.out_err}
                  : {b1.in_ready, b1.out_valid, b1.out_data, b1.out_carry, b1.out_zero, b1.out_err};
  endfunction

  function automatic void model(input logic [2:0] m, input logic [15:0] d, input int s,
                                output logic [15:0] r, output logic c, output logic e);
    logic [31:0] x;
    e = m >= 3'd6;
    r = d;
    c = 1'b0;
    if (!e && m != 3'd0 && s != 0)
      case (m)
        3'd1: begin x = {16'b0, d} << s; r = x[15:0]; c = x[16]; end
        3'd2: begin x = {d, 16'b0} >> s; r = x[31:16]; c = x[15]; end
        3'd3: begin x = $unsigned($signed({d, 16'b0}) >>> s); r = x[31:16]; c = x[15]; end
        3'd4: begin x = {d, d} << s; r = x[31:16]; c = r[0]; end
        default: begin x = {d, d} >> s; r = x[15:0]; c = r[15]; end
      endcase
  endfunction

  function automatic int lat(input logic [2:0] m, input int s, input int step);
    return (m == 3'd0 || m >= 3'd6 || s == 0) ? 1 : 1 + (s + step - 1) / step;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [2:0] m, input logic [15:0] d, input logic [3:0] s);
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_shamt = 4'($urandom);
    in_mode  = 3'($urandom);
  endtask

  task automatic do_op(input logic [2:0] m, input logic [15:0] d, input logic [3:0] s,
                       input logic [15:0] er, input logic ec, input logic ez, input logic ee);
    bit          got [2];
    int          lt [2];
    logic [20:0] o [2];
    logic [20:0] t;
    got = '{0, 0};
    lt  = '{0, 0};
    o   = '{'0, '0};
    start(m, d, s);
    for (int i = 1; i <= 40 && !(got[0] && got[1]); i++) begin
      for (int k = 0; k < 2; k++) begin
        t = snap(k);
        if (!got[k] && t[19]) begin got[k] = 1; lt[k] = i; o[k] = t; end
      end
      if (!(got[0] && got[1])) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("s%0d valid seen m%0d s%0d", k ? 4 : 1, m, s), 32'(got[k]), 32'd1);
      if (got[k]) begin
        chk($sformatf("s%0d latency m%0d s%0d", k ? 4 : 1, m, s), 32'(lt[k]), 32'(lat(m, int'(s), k ? 4 : 1)));
        chk($sformatf("s%0d result m%0d d%0h s%0d", k ? 4 : 1, m, d, s), 32'(o[k][18:0]), 32'({er, ec, ez, ee}));
        chk($sformatf("s%0d in_ready in DONE", k ? 4 : 1), 32'(o[k][20]), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t = snap(k);
      chk($sformatf("s%0d idle after op", k ? 4 : 1), 32'(t[20:19]), 32'b10);
    end
  endtask

  initial begin
    vec_t        tbl [11];
    logic [15:0] r;
    logic        c, e;
    logic [2:0]  m;
    logic [15:0] d;
    logic [3:0]  s;
    logic [20:0] t;
    bit          ok;
    tbl = '{
      '{3'd3, 16'h8001, 4'd3,  16'hF000, 1'b0, 1'b0, 1'b0},
      '{3'd4, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b0, 1'b0},
      '{3'd5, 16'h0001, 4'd15, 16'h0002, 1'b0, 1'b0, 1'b0},
      '{3'd2, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0},
      '{3'd1, 16'h00FF, 4'd6,  16'h3FC0, 1'b0, 1'b0, 1'b0},
      '{3'd7, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b0, 1'b1},
      '{3'd6, 16'h0000, 4'd3,  16'h0000, 1'b0, 1'b1, 1'b1},
      '{3'd0, 16'hABCD, 4'd9,  16'hABCD, 1'b0, 1'b0, 1'b0},
      '{3'd1, 16'h8001, 4'd0,  16'h8001, 1'b0, 1'b0, 1'b0},
      '{3'd1, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0},
      '{3'd5, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0}
    };
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("s%0d reset outputs", k ? 4 : 1), 32'(snap(k)), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready before first edge", 32'(b1.in_ready), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t = snap(k);
      chk($sformatf("s%0d in_ready after reset", k ? 4 : 1), 32'(t[20]), 32'd1);
    end
    for (int i = 0; i < 11; i++)
      do_op(tbl[i].m, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].e);

    // back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    start(3'd1, 16'h0F0F, 4'd2);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (b1.out_valid) ok = 1; else begin @(posedge clk); #1; end
    end
    chk("hold valid seen", 32'(ok), 32'd1);
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("s%0d hold cycle %0d", k ? 4 : 1, j), 32'(snap(k)), 32'({2'b01, 16'h3C3C, 3'b000}));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t = snap(k);
      chk($sformatf("s%0d ready after handshake", k ? 4 : 1), 32'(t[20:19]), 32'b10);
    end

    // abort mid-SHIFT
    out_ready = 1'b0;
    start(3'd1, 16'h0001, 4'd15);
    for (int j = 0; j < 2; j++) begin
      chk("abort pre valid", 32'({b1.out_valid, b4.out_valid}), 32'd0);
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("abort idle", 32'({b1.in_ready, b4.in_ready, b1.out_valid, b4.out_valid}), 32'b1100);
      @(posedge clk);
      #1;
    end
    do_op(3'd1, 16'h0001, 4'd2, 16'h0004, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-SHIFT
    start(3'd1, 16'h0001, 4'd15);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("s%0d async reset", k ? 4 : 1), 32'(snap(k)), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t = snap(k);
      chk($sformatf("s%0d ready after mid reset", k ? 4 : 1), 32'(t[20:19]), 32'b10);
    end
    do_op(3'd1, 16'h0001, 4'd2, 16'h0004, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      m = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      s = 4'($urandom_range(0, 15));
      model(m, d, int'(s), r, c, e);
      do_op(m, d, s, r, c, r == 16'h0000, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
